// File: rtl/crc_frame_writer.sv
// Byte-stream frame writer: stores payload bytes from address 0, computes CRC-16/USB
// on the fly and appends the inverted CRC (low byte first) directly after the payload.
module crc_frame_writer #(
  parameter int ADDR_W  = 10,
  parameter int MAX_LEN = 1022
) (
  input  logic              clk50m,
  input  logic              rst_n,
  input  logic              frm_start,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [15:0]       crc_out,
  output logic [ADDR_W-1:0] frm_len,
  output logic              frm_done,
  output logic              frm_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CRC_LO,
    S_CRC_HI,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LEN_LIMIT = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_inc;
  logic [15:0]       crc;
  logic [15:0]       crc_nxt;
  logic              accept;
  logic              at_limit;

  // Reflected CRC-16 (poly 0xA001), one full byte per clock.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int unsigned i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign din_ready = (state == S_DATA);
  assign accept    = din_valid & din_ready;
  assign count_inc = count + ONE;
  assign at_limit  = (count_inc == LEN_LIMIT);
  assign crc_nxt   = crc16_byte(crc, din);

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frm_start) state_nxt = S_DATA;
      S_DATA:   if (accept && (din_last || at_limit)) state_nxt = S_CRC_LO;
      S_CRC_LO: state_nxt = S_CRC_HI;
      S_CRC_HI: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      crc       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      crc_out   <= '0;
      frm_len   <= '0;
      frm_done  <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      frm_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frm_start) begin
            crc     <= '1;
            count   <= '0;
            frm_err <= 1'b0;
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= count;
            mem_wdata <= din;
            count     <= count_inc;
            crc       <= crc_nxt;
            if (at_limit && !din_last) frm_err <= 1'b1;
          end
        end
        // count already equals the payload length here
        S_CRC_LO: begin
          mem_we    <= 1'b1;
          mem_addr  <= count;
          mem_wdata <= ~crc[7:0];
        end
        S_CRC_HI: begin
          mem_we    <= 1'b1;
          mem_addr  <= count_inc;
          mem_wdata <= ~crc[15:8];
        end
        S_DONE: begin
          crc_out  <= ~crc;
          frm_len  <= count;
          frm_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
